// File: rtl/fft_bitrev_unscramble.sv
// Ping-pong reorder buffer: takes FFT frames in bit-reversed order and streams them out in natural order.
// Define FFT_UNSCRAMBLE_FLUSH_EN to add a synchronous active-high flush port.
module fft_bitrev_unscramble #(
  parameter int SAMPLES = 8,
  parameter int WIDTH   = 3,
  parameter int AW      = $clog2(SAMPLES)
) (
  input  logic             clk,
  input  logic             rst_n,
`ifdef FFT_UNSCRAMBLE_FLUSH_EN
  input  logic             flush,
`endif
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [AW-1:0]    out_index,
  output logic             out_last
);

  typedef enum logic [1:0] {EMPTY, FILLING, FULL, DRAINING} bank_state_e;

  localparam logic [AW-1:0] LAST = AW'(SAMPLES - 1);

  bank_state_e      state [2];
  logic [WIDTH-1:0] mem [2][SAMPLES];
  logic             wb;
  logic             rb;
  logic [AW-1:0]    wr_cnt;
  logic [AW-1:0]    rd_cnt;
  logic             flush_now;
  logic             in_fire;
  logic             out_fire;

`ifdef FFT_UNSCRAMBLE_FLUSH_EN
  assign flush_now = flush;
`else
  assign flush_now = 1'b0;
`endif

  function automatic logic [AW-1:0] bitrev(input logic [AW-1:0] idx);
    logic [AW-1:0] r;
    for (int i = 0; i < AW; i++) begin
      r[i] = idx[AW-1-i];
    end
    return r;
  endfunction

  assign in_ready  = (state[wb] == EMPTY) || (state[wb] == FILLING);
  assign out_valid = (state[rb] == FULL)  || (state[rb] == DRAINING);
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;

  assign out_data  = out_valid ? mem[rb][rd_cnt] : '0;
  assign out_index = out_valid ? rd_cnt : '0;
  assign out_last  = out_valid && (rd_cnt == LAST);

  // Storage is deliberately left unreset; the bank states decide what is live.
  always_ff @(posedge clk) begin
    if (in_fire && !flush_now) begin
      mem[wb][bitrev(wr_cnt)] <= in_data;
    end
  end

  // Writer and reader can never own the same bank at once (their legal states are
  // disjoint), so both updates below always touch different banks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state[0] <= EMPTY;
      state[1] <= EMPTY;
      wb       <= 1'b0;
      rb       <= 1'b0;
      wr_cnt   <= '0;
      rd_cnt   <= '0;
    end else if (flush_now) begin
      state[0] <= EMPTY;
      state[1] <= EMPTY;
      wb       <= 1'b0;
      rb       <= 1'b0;
      wr_cnt   <= '0;
      rd_cnt   <= '0;
    end else begin
      if (in_fire) begin
        state[wb] <= (wr_cnt == LAST) ? FULL : FILLING;
        wr_cnt    <= wr_cnt + AW'(1);
        if (wr_cnt == LAST) begin
          wb <= ~wb;
        end
      end
      if (out_fire) begin
        state[rb] <= (rd_cnt == LAST) ? EMPTY : DRAINING;
        rd_cnt    <= rd_cnt + AW'(1);
        if (rd_cnt == LAST) begin
          rb <= ~rb;
        end
      end
    end
  end

endmodule

// File: tb/tb_fft_bitrev_unscramble.sv
// Directed self-checking bench for fft_bitrev_unscramble (SAMPLES=8, WIDTH=3).
// Exercises the flush port as well when FFT_UNSCRAMBLE_FLUSH_EN is defined.
module tb_fft_bitrev_unscramble;

  localparam int SAMPLES = 8;
  localparam int WIDTH   = 3;
  localparam int AW      = 3;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_data = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] out_data;
  logic [AW-1:0]    out_index;
  logic             out_last;
`ifdef FFT_UNSCRAMBLE_FLUSH_EN
  logic             flush = 1'b0;
`endif

  int total = 0;
  int bad   = 0;
  int brev [8] = '{0, 4, 2, 6, 1, 5, 3, 7};

  fft_bitrev_unscramble #(.SAMPLES(SAMPLES), .WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
`ifdef FFT_UNSCRAMBLE_FLUSH_EN
    .flush     (flush),
`endif
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_index (out_index),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // mode 0 feeds tags that come out as n; mode 1 feeds tags that come out as 7-n.
  function automatic int sample_for(input int mode, input int pos);
    return (mode != 0) ? (7 - brev[pos % 8]) : brev[pos % 8];
  endfunction

  task automatic apply_stimulus(input int mode, input int first, input int count);
    for (int k = first; k < first + count; k++) begin
      int waits = 0;
      in_valid = 1'b1;
      in_data  = 3'(sample_for(mode, k));
      while (!in_ready && waits < 50) begin
        tick();
        waits++;
      end
      if (waits >= 50) check_output("send_timeout", 0, 1);
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic drain_frame(input int mode);
    out_ready = 1'b1;
    for (int n = 0; n < 8; n++) begin
      int waits = 0;
      while (!out_valid && waits < 50) begin
        tick();
        waits++;
      end
      if (waits >= 50) check_output("drain_timeout", 0, 1);
      check_output("drain_data", int'(out_data), (mode != 0) ? 7 - n : n);
      check_output("drain_index", int'(out_index), n);
      check_output("drain_last", int'(out_last), (n == 7) ? 1 : 0);
      tick();
    end
    out_ready = 1'b0;
  endtask

  initial begin
    int sent, got, drops, idle, held, hd, hi;

    tick();
    check_output("rst_in_ready", int'(in_ready), 1);
    check_output("rst_out_valid", int'(out_valid), 0);
    check_output("rst_out_data", int'(out_data), 0);
    check_output("rst_out_index", int'(out_index), 0);
    check_output("rst_out_last", int'(out_last), 0);
    tick();
    rst_n = 1'b1;
    tick();

    // single frame, back-to-back, latency of first output
    $display("[TB] single frame");
    out_ready = 1'b1;
    apply_stimulus(0, 0, 7);
    check_output("pre_valid", int'(out_valid), 0);
    apply_stimulus(0, 7, 1);
    check_output("first_valid", int'(out_valid), 1);
    drain_frame(0);
    check_output("after_single_valid", int'(out_valid), 0);
    check_output("after_single_ready", int'(in_ready), 1);

    // four frames streamed with both sides always willing
    $display("[TB] streaming");
    out_ready = 1'b1;
    sent = 0; got = 0; drops = 0; idle = 0;
    for (int c = 0; c < 200 && got < 32; c++) begin
      in_valid = (sent < 32);
      in_data  = 3'(brev[sent % 8]);
      if (sent > 0 && sent < 32 && !in_ready) drops++;
      if (out_valid) begin
        check_output("stream_data", int'(out_data), got % 8);
        check_output("stream_index", int'(out_index), got % 8);
        got++;
      end else if (got > 0) begin
        idle++;
      end
      if (in_valid && in_ready) sent++;
      tick();
    end
    in_valid = 1'b0;
    check_output("stream_count", got, 32);
    check_output("stream_ready_drops", drops, 0);
    check_output("stream_idle", idle, 0);

    // backpressure: both banks fill, then drain
    $display("[TB] backpressure");
    out_ready = 1'b0;
    sent = 0;
    for (int c = 0; c < 24; c++) begin
      in_valid = 1'b1;
      in_data  = 3'(sample_for((sent < 8) ? 1 : 0, sent));
      if (in_ready) sent++;
      tick();
    end
    in_valid = 1'b0;
    check_output("bp_accepted", sent, 16);
    check_output("bp_in_ready", int'(in_ready), 0);
    check_output("bp_stall_valid", int'(out_valid), 1);
    check_output("bp_stall_data", int'(out_data), 7);
    tick();
    tick();
    check_output("bp_stall_data_held", int'(out_data), 7);
    check_output("bp_stall_index_held", int'(out_index), 0);
    drain_frame(1);
    check_output("bp_ready_back", int'(in_ready), 1);
    drain_frame(0);
    check_output("bp_empty", int'(out_valid), 0);

    // random handshakes over 20 frames
    $display("[TB] random");
    sent = 0; got = 0; held = 0; hd = 0; hi = 0;
    for (int c = 0; c < 3000 && got < 160; c++) begin
      in_valid  = (sent < 160) && ($urandom_range(0, 1) == 1);
      in_data   = 3'(brev[sent % 8]);
      out_ready = ($urandom_range(0, 1) == 1);
      if (held != 0) begin
        check_output("rnd_hold_valid", int'(out_valid), 1);
        check_output("rnd_hold_data", int'(out_data), hd);
        check_output("rnd_hold_index", int'(out_index), hi);
      end
      if (out_valid && out_ready) begin
        check_output("rnd_data", int'(out_data), got % 8);
        check_output("rnd_index", int'(out_index), got % 8);
        check_output("rnd_last", int'(out_last), ((got % 8) == 7) ? 1 : 0);
        got++;
      end
      held = (out_valid && !out_ready) ? 1 : 0;
      hd   = int'(out_data);
      hi   = int'(out_index);
      if (in_valid && in_ready) sent++;
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check_output("rnd_out_count", got, 160);
    check_output("rnd_in_count", sent, 160);
    check_output("rnd_empty", int'(out_valid), 0);

    // reset in the middle of the second frame
    $display("[TB] mid-frame reset");
    apply_stimulus(0, 0, 8);
    apply_stimulus(0, 0, 5);
    check_output("mr_valid_before", int'(out_valid), 1);
    rst_n = 1'b0;
    #1;
    check_output("mr_valid", int'(out_valid), 0);
    check_output("mr_ready", int'(in_ready), 1);
    check_output("mr_data", int'(out_data), 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    out_ready = 1'b1;
    apply_stimulus(1, 0, 7);
    check_output("mr_no_residue", int'(out_valid), 0);
    apply_stimulus(1, 7, 1);
    drain_frame(1);

`ifdef FFT_UNSCRAMBLE_FLUSH_EN
    // flush with one bank full and the other partially filled
    $display("[TB] flush");
    out_ready = 1'b0;
    apply_stimulus(1, 0, 8);
    apply_stimulus(1, 0, 3);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check_output("fl_valid", int'(out_valid), 0);
    check_output("fl_ready", int'(in_ready), 1);
    apply_stimulus(0, 0, 8);
    drain_frame(0);
    check_output("fl_empty", int'(out_valid), 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
